// File: rtl/keys_pkg.sv
// keys_pkg: shared defaults and key polarity for the keyboard front end
package keys_pkg;
    localparam int NUM_KEYS_DEF = 61;
    localparam int PRESCALE_DEF = 12000;
    localparam int DEBOUNCE_TICKS_DEF = 5;
    localparam logic KEY_PRESSED = 1'b1;
endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: per-key tick counter and clean state flop
module key_debounce_cell
    import keys_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic sync_i,
    output logic state_o,
    output logic chg_o
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    logic [CW-1:0] cnt;
    logic diff;
    assign diff = sync_i != state_o;
    assign chg_o = tick_i && diff && cnt == CW'(DEBOUNCE_TICKS - 1);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
            state_o <= ~KEY_PRESSED;
        end else if (tick_i) begin
            cnt <= (diff && !chg_o) ? cnt + 1'b1 : '0;
            if (chg_o) state_o <= sync_i;
        end
    end
endmodule

// File: rtl/key_debounce_sync.sv
// key_debounce_sync: two-flop synchronizer plus per-key debounce of the key matrix lines.
// KEYS_DEBOUNCE_EN builds the prescaler/counter path; without it keys_o follows the synchronizer.
module key_debounce_sync
    import keys_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                keys_chg_o
);
    logic [NUM_KEYS-1:0] s1, s2;
    if (NUM_KEYS < 1 || NUM_KEYS > 4096 || PRESCALE < 2 || DEBOUNCE_TICKS < 1) begin : g_bad_param
        $error("key_debounce_sync: illegal parameter value");
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= keys_i;
            s2 <= s1;
        end
    end
`ifdef KEYS_DEBOUNCE_EN
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] pre;
    logic tick;
    logic [NUM_KEYS-1:0] chg;
    assign tick = pre == PW'(PRESCALE - 1);
    always_ff @(posedge clk_i) begin
        if (rst_i) pre <= '0;
        else pre <= tick ? '0 : pre + 1'b1;
    end
    for (genvar n = 0; n < NUM_KEYS; n++) begin : g_cell
        key_debounce_cell #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_cell (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .tick_i (tick),
            .sync_i (s2[n]),
            .state_o(keys_o[n]),
            .chg_o  (chg[n])
        );
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) keys_chg_o <= 1'b0;
        else keys_chg_o <= |chg;
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            keys_o <= '0;
            keys_chg_o <= 1'b0;
        end else begin
            keys_o <= s2;
            keys_chg_o <= |(s2 ^ keys_o);
        end
    end
`endif
endmodule

// File: tb/tb_key_debounce_sync.sv
// tb_key_debounce_sync: directed checks of reset, debounce timing, glitch rejection and pass-through mode
module tb_key_debounce_sync;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic [7:0] keys_i = 8'h00;
    logic [7:0] keys_o;
    logic keys_chg_o;
    int errors = 0;
    int checks = 0;

    key_debounce_sync #(.NUM_KEYS(8), .PRESCALE(4), .DEBOUNCE_TICKS(3)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .keys_i    (keys_i),
        .keys_o    (keys_o),
        .keys_chg_o(keys_chg_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic chk_it);
        rst_i = 1'b1;
        keys_i = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            if (chk_it) begin
                check("rst_keys", keys_o, 8'h00);
                check("rst_chg", keys_chg_o, 1'b0);
            end
        end
        rst_i = 1'b0;
        keys_i = 8'h00;
        step();
        if (chk_it) begin
            check("post_rst_keys", keys_o, 8'h00);
            check("post_rst_chg", keys_chg_o, 1'b0);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    // Watches n cycles: first cycle keys_o leaves prev, its value, strobe at that cycle, total strobes
    task automatic watch(input int n, input logic [7:0] prev, output int first,
                         output logic [7:0] val, output logic chg_at, output int pulses);
        first = -1;
        val = prev;
        chg_at = 1'b0;
        pulses = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (keys_chg_o) pulses++;
            if (first < 0 && keys_o != prev) begin
                first = i;
                val = keys_o;
                chg_at = keys_chg_o;
            end
        end
    endtask

    int first, pulses;
    logic [7:0] val;
    logic chg_at;

    initial begin
        do_reset(1'b1);
`ifdef KEYS_DEBOUNCE_EN
        keys_i = 8'h08;
        repeat (6) step();
        keys_i = 8'h00;
        watch(20, 8'h00, first, val, chg_at, pulses);
        check("glitch_first", first, -1);
        check("glitch_pulses", pulses, 0);
        check("glitch_keys", keys_o, 8'h00);

        do_reset(1'b0);
        keys_i = 8'h01;
        watch(24, 8'h00, first, val, chg_at, pulses);
        check("press_min", first >= 11, 1'b1);
        check("press_max", first <= 14 && first > 0, 1'b1);
        check("press_val", val, 8'h01);
        check("press_chg_at", chg_at, 1'b1);
        check("press_pulses", pulses, 1);

        do_reset(1'b0);
        keys_i = 8'hA5;
        watch(24, 8'h00, first, val, chg_at, pulses);
        check("simul_val", val, 8'hA5);
        check("simul_chg_at", chg_at, 1'b1);
        check("simul_pulses", pulses, 1);
        keys_i = 8'h25;
        watch(24, 8'hA5, first, val, chg_at, pulses);
        check("rel7_val", val, 8'h25);
        check("rel7_pulses", pulses, 1);
        check("rel7_keys", keys_o, 8'h25);

        // Two ticks into the press, then a one-cycle reset restarts the whole count
        rst_i = 1'b1;
        keys_i = 8'h00;
        step();
        rst_i = 1'b0;
        keys_i = 8'h02;
        repeat (8) step();
        check("midrst_pre", keys_o, 8'h00);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_in", keys_o, 8'h00);
        watch(16, 8'h00, first, val, chg_at, pulses);
        check("midrst_first", first, 12);
        check("midrst_val", val, 8'h02);
        check("midrst_pulses", pulses, 1);
`else
        keys_i = 8'h3C;
        step();
        check("pt1_e1", keys_o, 8'h00);
        step();
        check("pt1_e2", keys_o, 8'h00);
        check("pt1_e2_chg", keys_chg_o, 1'b0);
        step();
        check("pt1_e3", keys_o, 8'h3C);
        check("pt1_e3_chg", keys_chg_o, 1'b1);
        step();
        check("pt1_e4", keys_o, 8'h3C);
        check("pt1_e4_chg", keys_chg_o, 1'b0);
        keys_i = 8'hC3;
        step();
        step();
        check("pt2_e2", keys_o, 8'h3C);
        step();
        check("pt2_e3", keys_o, 8'hC3);
        check("pt2_e3_chg", keys_chg_o, 1'b1);
        step();
        check("pt2_e4_chg", keys_chg_o, 1'b0);
        rst_i = 1'b1;
        step();
        check("pt_rst_keys", keys_o, 8'h00);
        check("pt_rst_chg", keys_chg_o, 1'b0);
        rst_i = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
